// File: rtl/tail_light_request_sequencer.sv
// Driver-input front end for light_controller: synchronise, debounce, arbitrate turn/hazard requests, pace sweeps.
// Define TAIL_LANE_CHANGE_EN to enforce MIN_SWEEPS complete sweeps before a released stalk returns to idle.
module tail_light_request_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_DIV        = 8,
  parameter int SWEEP_STEPS     = 4,
  parameter int MIN_SWEEPS      = 3,
  parameter int GAP_STEPS       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic brake_in,
  input  logic left_stalk,
  input  logic right_stalk,
  input  logic hazard_sw,
  output logic brake,
  output logic turn_left,
  output logic turn_right,
  output logic step_en,
  output logic sweep_done
);

  localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SW  = (SWEEP_STEPS > 1) ? $clog2(SWEEP_STEPS) : 1;
  localparam int GW  = (GAP_STEPS > 1) ? $clog2(GAP_STEPS) : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0]  PRE_LAST  = PW'(STEP_DIV - 1);
  localparam logic [SW-1:0]  STEP_LAST = SW'(SWEEP_STEPS - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_STEPS - 1);

  localparam int BRK = 0;
  localparam int LFT = 1;
  localparam int RGT = 2;
  localparam int HZD = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEFT   = 3'd1,
    S_RIGHT  = 3'd2,
    S_HAZARD = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  logic [3:0]     raw;
  logic [3:0]     sync1_q, sync2_q, db_q, req_q;
  logic [DBW-1:0] db_cnt_q [4];

  state_t         state_q, state_d, target_q, target_d;
  logic [PW-1:0]  pre_q;
  logic [SW-1:0]  step_q;
  logic [GW-1:0]  gap_q;
  logic           turn_left_q, turn_right_q;
  logic           step_tick, boundary, min_met, restart;

  assign raw = {hazard_sw, right_stalk, left_stalk, brake_in};

  // The counter tracks consecutive samples that disagree with the current level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      req_q   <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      req_q   <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_LAST) begin
            db_q[i]     <= sync2_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign brake      = req_q[BRK];
  assign turn_left  = turn_left_q;
  assign turn_right = turn_right_q;

  assign step_tick  = (state_q != S_IDLE) && (pre_q == PRE_LAST);
  assign boundary   = step_tick && (step_q == STEP_LAST) && (state_q != S_GAP);
  assign step_en    = step_tick;
  assign sweep_done = boundary;

`ifdef TAIL_LANE_CHANGE_EN
  localparam int MW = (MIN_SWEEPS > 0) ? $clog2(MIN_SWEEPS + 1) : 1;
  localparam logic [MW-1:0] SWEEP_SAT = MW'(MIN_SWEEPS);

  logic [MW-1:0] sweep_q;

  // The sweep finishing in this cycle counts toward the minimum.
  assign min_met = (int'(sweep_q) + 1) >= MIN_SWEEPS;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_q <= '0;
    end else if (restart) begin
      sweep_q <= '0;
    end else if (boundary && (sweep_q != SWEEP_SAT)) begin
      sweep_q <= sweep_q + 1'b1;
    end
  end
`else
  // Without lane-change mode any release exits at the next sweep boundary.
  assign min_met = (MIN_SWEEPS >= 0);
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (req_q[HZD])                      state_d = S_HAZARD;
        else if (req_q[LFT] && !req_q[RGT])  state_d = S_LEFT;
        else if (req_q[RGT] && !req_q[LFT])  state_d = S_RIGHT;
      end
      S_LEFT: begin
        if (req_q[HZD]) begin
          state_d = S_HAZARD;
        end else if (boundary && req_q[RGT] && !req_q[LFT]) begin
          state_d  = S_GAP;
          target_d = S_RIGHT;
        end else if (boundary && !req_q[LFT] && min_met) begin
          state_d = S_IDLE;
        end
      end
      S_RIGHT: begin
        if (req_q[HZD]) begin
          state_d = S_HAZARD;
        end else if (boundary && req_q[LFT] && !req_q[RGT]) begin
          state_d  = S_GAP;
          target_d = S_LEFT;
        end else if (boundary && !req_q[RGT] && min_met) begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (req_q[HZD])                      state_d = S_HAZARD;
        else if (step_tick && gap_q == GAP_LAST) state_d = target_q;
      end
      S_HAZARD: begin
        if (boundary && !req_q[HZD])         state_d = S_IDLE;
      end
      default:                               state_d = S_IDLE;
    endcase
  end

  assign restart = (state_d != state_q) || (state_d == S_IDLE);

  // Pacing counters restart on every state entry so each state begins a fresh step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      target_q     <= S_IDLE;
      turn_left_q  <= 1'b0;
      turn_right_q <= 1'b0;
      pre_q        <= '0;
      step_q       <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      turn_left_q  <= (state_d == S_LEFT)  || (state_d == S_HAZARD);
      turn_right_q <= (state_d == S_RIGHT) || (state_d == S_HAZARD);
      if (restart) begin
        pre_q  <= '0;
        step_q <= '0;
        gap_q  <= '0;
      end else begin
        pre_q <= step_tick ? '0 : pre_q + 1'b1;
        if (step_tick) begin
          step_q <= (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
          if (state_q == S_GAP) gap_q <= gap_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tail_light_request_sequencer.sv
// Self-checking bench for tail_light_request_sequencer: directed scenarios plus randomized input segments,
// checked every cycle against an elapsed-time reference model.
module tb_tail_light_request_sequencer;

  localparam int D  = 4;
  localparam int SD = 8;
  localparam int SS = 4;
  localparam int MS = 3;
  localparam int GS = 1;
  localparam int SWEEP_CYC = SD * SS;
`ifdef TAIL_LANE_CHANGE_EN
  localparam int MIN_EFF = MS;
`else
  localparam int MIN_EFF = 1;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_LEFT  = 1;
  localparam int M_RIGHT = 2;
  localparam int M_HAZ   = 3;
  localparam int M_GAP   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic brake_in = 1'b0, left_stalk = 1'b0, right_stalk = 1'b0, hazard_sw = 1'b0;
  logic brake, turn_left, turn_right, step_en, sweep_done;

  tail_light_request_sequencer #(
    .DEBOUNCE_CYCLES(D), .STEP_DIV(SD), .SWEEP_STEPS(SS), .MIN_SWEEPS(MS), .GAP_STEPS(GS)
  ) dut (
    .clk(clk), .rst(rst),
    .brake_in(brake_in), .left_stalk(left_stalk), .right_stalk(right_stalk), .hazard_sw(hazard_sw),
    .brake(brake), .turn_left(turn_left), .turn_right(turn_right),
    .step_en(step_en), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: raw sample history, debounced and requested levels, mode and cycles since entry.
  logic [3:0] samp[$];
  logic [3:0] m_db, m_req;
  int m_mode, m_tgt, m_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    samp.delete();
    for (int j = 0; j < D + 2; j++) samp.push_front(4'b0);
    m_db = '0; m_req = '0;
    m_mode = M_IDLE; m_tgt = M_IDLE; m_t = 0;
  endtask

  task automatic model_step();
    logic [3:0] raw_now;
    logic stp, bnd, lft, rgt, hzd, flip;
    int nm, swept;
    raw_now = {hazard_sw, right_stalk, left_stalk, brake_in};
    if (rst) begin
      model_reset();
    end else begin
      stp   = (m_mode != M_IDLE) && (m_t % SD == SD - 1);
      bnd   = stp && (m_mode != M_GAP) && (m_t % SWEEP_CYC == SWEEP_CYC - 1);
      swept = (m_t + 1) / SWEEP_CYC;
      lft = m_req[1]; rgt = m_req[2]; hzd = m_req[3];
      nm = m_mode;
      case (m_mode)
        M_IDLE:  if (hzd) nm = M_HAZ; else if (lft && !rgt) nm = M_LEFT; else if (rgt && !lft) nm = M_RIGHT;
        M_LEFT:  if (hzd) nm = M_HAZ;
                 else if (bnd && rgt && !lft) begin nm = M_GAP; m_tgt = M_RIGHT; end
                 else if (bnd && !lft && swept >= MIN_EFF) nm = M_IDLE;
        M_RIGHT: if (hzd) nm = M_HAZ;
                 else if (bnd && lft && !rgt) begin nm = M_GAP; m_tgt = M_LEFT; end
                 else if (bnd && !rgt && swept >= MIN_EFF) nm = M_IDLE;
        M_GAP:   if (hzd) nm = M_HAZ; else if (m_t == GS * SD - 1) nm = m_tgt;
        M_HAZ:   if (bnd && !hzd) nm = M_IDLE;
        default: nm = M_IDLE;
      endcase
      if (nm != m_mode) begin m_mode = nm; m_t = 0; end
      else if (m_mode != M_IDLE) m_t++;
      m_req = m_db;
      samp.push_front(raw_now);
      void'(samp.pop_back());
      // A level flips once the last D synchronised samples all disagree with it.
      for (int i = 0; i < 4; i++) begin
        flip = 1'b1;
        for (int j = 2; j <= D + 1; j++) if (samp[j][i] == m_db[i]) flip = 1'b0;
        if (flip) m_db[i] = ~m_db[i];
      end
    end
  endtask

  function automatic logic [31:0] exp_vec();
    logic st, sw;
    st = (m_mode != M_IDLE) && (m_t % SD == SD - 1);
    sw = st && (m_mode != M_GAP) && (m_t % SWEEP_CYC == SWEEP_CYC - 1);
    return {27'd0, m_req[0], (m_mode == M_LEFT || m_mode == M_HAZ),
            (m_mode == M_RIGHT || m_mode == M_HAZ), st, sw};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {27'd0, brake, turn_left, turn_right, step_en, sweep_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("outputs", obs_vec(), exp_vec());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n, g, c_tl, c_st, c_sw, hold;
    model_reset();

    // Reset held with toggling inputs, then quiet idle.
    for (int i = 0; i < 5; i++) begin
      {hazard_sw, right_stalk, left_stalk, brake_in} = 4'($urandom);
      tick();
    end
    {hazard_sw, right_stalk, left_stalk, brake_in} = 4'b0;
    rst = 1'b0;
    ticks(50);

    // Short pulses are rejected.
    left_stalk = 1'b1; ticks(2); left_stalk = 1'b0;
    c_tl = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (turn_left) c_tl++; end
    check("left_pulse_ignored", c_tl, 0);
    brake_in = 1'b1; ticks(D - 1); brake_in = 1'b0;
    c_tl = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (brake) c_tl++; end
    check("brake_pulse_ignored", c_tl, 0);

    // Brake latency on both edges.
    brake_in = 1'b1; n = 0;
    do begin tick(); n++; end while (!brake && n < 30);
    check("brake_rise_latency", n, D + 3);
    ticks(10);
    brake_in = 1'b0; n = 0;
    do begin tick(); n++; end while (brake && n < 30);
    check("brake_fall_latency", n, D + 3);

    // Brief left request: sweeps until release rules allow exit.
    c_tl = 0; c_st = 0; c_sw = 0;
    left_stalk = 1'b1;
    for (int i = 0; i < 158; i++) begin
      if (i == 8) left_stalk = 1'b0;
      tick();
      if (turn_left) c_tl++;
      if (step_en) c_st++;
      if (sweep_done) c_sw++;
    end
    check("lane_change_on_cycles", c_tl, MIN_EFF * SWEEP_CYC);
    check("lane_change_steps", c_st, MIN_EFF * SS);
    check("lane_change_sweeps", c_sw, MIN_EFF);

    // Direction reversal inserts a blank gap.
    left_stalk = 1'b1; ticks(80);
    left_stalk = 1'b0; right_stalk = 1'b1;
    n = 0;
    do begin tick(); n++; end while (turn_left && n < 100);
    check("reverse_left_drops", n < 100, 1);
    g = 1;
    while (!turn_right && g < 50) begin
      tick();
      if (!turn_right && !turn_left) g++;
    end
    check("gap_length", g, GS * SD);

    // Hazard overrides an active right turn.
    ticks(20);
    hazard_sw = 1'b1; n = 0;
    do begin tick(); n++; end while (!(turn_left && turn_right) && n < 30);
    check("hazard_latency", n, D + 4);
    n = 0;
    do begin tick(); n++; end while (!step_en && n < 30);
    check("hazard_prescaler_restart", n, SD - 1);
    ticks(30);
    hazard_sw = 1'b0; ticks(80);
    right_stalk = 1'b0; ticks(150);
    check("settled_idle", {turn_left, turn_right}, 2'b00);

    // Brake with hazard, then an asynchronous reset mid-sweep.
    brake_in = 1'b1; hazard_sw = 1'b1; ticks(20);
    check("brake_hazard_on", {brake, turn_left, turn_right}, 3'b111);
    ticks(13);
    #2 rst = 1'b1;
    #1 check("async_reset_clears", obs_vec(), 32'd0);
    tick();
    rst = 1'b0; n = 0;
    do begin tick(); n++; end while (!brake && n < 30);
    check("post_reset_brake_latency", n, D + 3);
    tick();
    check("post_reset_hazard_back", {turn_left, turn_right}, 2'b11);
    brake_in = 1'b0; hazard_sw = 1'b0; ticks(100);

    // Randomized segments with occasional resets.
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1; ticks($urandom_range(1, 3)); rst = 1'b0;
      end
      brake_in    = 1'($urandom_range(0, 1));
      hazard_sw   = ($urandom_range(0, 5) == 0);
      left_stalk  = ($urandom_range(0, 9) < 4);
      right_stalk = ($urandom_range(0, 9) < 4);
      hold = (seg % 5 == 0) ? $urandom_range(1, D) : $urandom_range(5, 70);
      ticks(hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tail_light_request_sequencer.md
Name: tail_light_request_sequencer

Overview:
- Front-end controller for light_controller.
- Takes raw driver inputs (left stalk, right stalk, hazard switch, brake pedal), then synchronises and debounces them.
- Arbitrates them into clean turn_left, turn_right and brake commands.
- Generates the step pacing tick that advances the sweep pattern.
- Enforces lane-change minimum sweeps, direction-change blanking and hazard priority.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required before a debounced level changes.
- STEP_DIV, 8: clock cycles per step_en pulse.
- SWEEP_STEPS, 4: step ticks per sweep (001, 011, 111, 000).
- MIN_SWEEPS, 3: minimum complete sweeps per turn request (lane-change mode).
- GAP_STEPS, 1: all-off step ticks inserted on a direction reversal.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- brake_in  input  1  raw brake pedal.
- left_stalk  input  1  raw left indicator request.
- right_stalk  input  1  raw right indicator request.
- hazard_sw  input  1  raw hazard switch.
- brake  output  1  debounced brake command to light_controller.
- turn_left  output  1  left turn command.
- turn_right  output  1  right turn command.
- step_en  output  1  one-cycle pacing pulse.
- sweep_done  output  1  one-cycle pulse at the end of each completed sweep.

Behaviour:
- **Reset:** all outputs 0, FSM in IDLE, all counters 0, synchronisers and debounced levels 0.
- **Synchronisation and debounce:**
  - Each raw input passes through a 2-flop synchroniser, then a debounce counter.
  - The debounced level takes the new value after DEBOUNCE_CYCLES consecutive equal samples.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
  - Raw edge to registered output latency is DEBOUNCE_CYCLES+3 cycles (7 at default).
- **brake:** registered copy of the debounced brake. Independent of the FSM and never blocked.
- **Prescaler:**
  - Counts 0..STEP_DIV-1 only while not in IDLE. step_en is asserted when count==STEP_DIV-1.
  - Cleared to 0 on every state entry, so the first step_en comes STEP_DIV cycles after entry.
- **Step and sweep counters:**
  - Step index runs 0..SWEEP_STEPS-1 and advances on step_en.
  - A sweep boundary is step_en while index==SWEEP_STEPS-1. sweep_done pulses in that same cycle.
  - The sweep counter saturates at MIN_SWEEPS. It is cleared on state entry.
- **FSM states:** IDLE, LEFT, RIGHT, HAZARD, GAP. Outputs are registered and decoded from the next state.
  - IDLE, all turn outputs 0:
    - hazard → HAZARD.
    - Else left only → LEFT.
    - Else right only → RIGHT.
    - left and right together (without hazard) → stay in IDLE.
  - LEFT, turn_left=1:
    - hazard → HAZARD immediately (same cycle, overrides everything).
    - right & !left at a sweep boundary → GAP, target RIGHT. Direction change ignores MIN_SWEEPS.
    - !left at a sweep boundary with sweep count ≥ MIN_SWEEPS (count includes the sweep just finishing) → IDLE.
  - RIGHT: mirror of LEFT.
  - GAP, both turn outputs 0:
    - After GAP_STEPS step ticks → target state.
    - hazard → HAZARD immediately.
  - HAZARD, turn_left=turn_right=1:
    - !hazard at a sweep boundary → IDLE. IDLE re-arbitrates on the next cycle.
- **Simultaneous events:** priority is hazard > direction change > release. brake never affects the FSM.
- **Reset mid-operation:** outputs drop to 0 asynchronously. After release, no output is asserted until inputs re-debounce.

Optional Feature:
- Macro: TAIL_LANE_CHANGE_EN.
- **Defined:** MIN_SWEEPS enforcement as described above.
- **Undefined:**
  - The sweep counter is not built.
  - LEFT and RIGHT exit to IDLE at the first sweep boundary where the stalk is released.
  - MIN_SWEEPS is ignored.

Test Plan:
1. rst high 5 cycles, all inputs toggling → all outputs 0, no step_en. After release with inputs 0 → outputs stay 0 for 50 cycles.
2. left_stalk pulse 2 cycles → no output change. brake_in held high → brake rises exactly 7 cycles after the raw edge; falls 7 cycles after release.
3. Feature on: left_stalk held 8 cycles then released → turn_left high 96 cycles (3 sweeps). Expect 12 step_en pulses and 3 sweep_done pulses, then IDLE. Feature off: same stimulus → turn_left high 32 cycles.
4. left held 80 cycles, then left released and right asserted mid-sweep → turn_left drops at the next sweep boundary. Both outputs 0 for 8 cycles (GAP), then turn_right=1.
5. hazard_sw asserted during RIGHT → both turns high 8 cycles after the raw edge (7-cycle debounce latency plus the immediate FSM transition), prescaler restarts. hazard released → exit at the next sweep boundary.
6. brake_in and hazard_sw together, then rst pulse mid-sweep → brake and both turns high. On rst, all outputs 0 the same cycle; they re-assert only after debounce.
